// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to the ALU, waits out
// mul/div latency, and writes Lower (and Upper for swap) back to the register file.
module alu_issue_ctrl #(
  parameter int DATA_W        = 17,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [3:0]        rf_raddr1,
  output logic [3:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_lower,
  input  logic [DATA_W-1:0] alu_upper,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              illegal,
  output logic              div_zero
);
  localparam int CW = $clog2(MULDIV_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB_LO, WB_HI} state_t;
  state_t state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, hi_q, hi_d, wdata_q, wdata_d;
  logic [3:0] op_q, op_d, waddr_q, waddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, busy_q, busy_d, we_q, we_d;
  logic [3:0] opc;
  logic legal, muldiv, swap, dz;
  assign opc    = ir_q[15:12];
  assign legal  = opc inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1011};
  assign muldiv = opc == 4'b0100 || opc == 4'b0101;
  assign swap   = opc == 4'b1000;
  assign dz     = opc == 4'b0101 && rf_rdata2 == '0;
  assign rf_raddr1   = ir_q[7:4];
  assign rf_raddr2   = ir_q[3:0];
  assign illegal     = state_q == READ && !legal;
  assign div_zero    = state_q == READ && dz;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign alu_data1   = d1_q;
  assign alu_data2   = d2_q;
  assign alu_op      = op_q;
  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: if (instr_valid && ready_q) begin
        ir_d    = instr;
        state_d = READ;
      end
      READ: if (!legal || dz) state_d = IDLE;
      else begin
        state_d = EXEC;
        d1_d    = rf_rdata1;
        d2_d    = rf_rdata2;
        op_d    = opc;
        cnt_d   = muldiv ? CW'(MULDIV_CYCLES - 1) : '0;
      end
      EXEC: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        state_d = WB_LO;
        hi_d    = alu_upper;
        we_d    = 1'b1;
        wdata_d = alu_lower;
        waddr_d = swap ? ir_q[7:4] : ir_q[11:8];
      end
      WB_LO: if (swap) begin
        state_d = WB_HI;
        we_d    = 1'b1;
        waddr_d = ir_q[3:0];
        wdata_d = hi_q;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller that drives the ALU operation interface: operands, 4-bit op code in, Lower/Upper results out.
- Accepts 16-bit instructions on a valid/ready handshake and reads two operands from the external register file.
- Sequences the ALU, including a multi-cycle wait for mul/div, then writes results back (two writes for swap).
- One instruction in flight at a time; no overlap, so no register hazards exist.

Parameters:
- DATA_W, 17, operand/result width, matching the ALU datapath.
- MULDIV_CYCLES, 4, EXEC cycles for mul/div (>=1); all other ops use 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept.
- instr  in  16  {opcode[15:12], rd[11:8], rs[7:4], rt[3:0]}.
- rf_raddr1  out  4  register file read address 1 (= rs).
- rf_raddr2  out  4  register file read address 2 (= rt).
- rf_rdata1  in  DATA_W  combinational read data for address 1.
- rf_rdata2  in  DATA_W  combinational read data for address 2.
- alu_data1  out  DATA_W  ALU Data1.
- alu_data2  out  DATA_W  ALU Data2.
- alu_op  out  4  ALU op code.
- alu_lower  in  DATA_W  ALU Lower result.
- alu_upper  in  DATA_W  ALU Upper result.
- rf_we  out  1  register file write enable.
- rf_waddr  out  4  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- busy  out  1  high whenever state != IDLE.
- illegal  out  1  one-cycle pulse: undefined opcode dropped.
- div_zero  out  1  one-cycle pulse: div with rt value 0; writeback suppressed.

Behaviour:
- Reset (rst=0, async): state=IDLE, every output register 0. instr_ready=1 once rst releases.
- Reset mid-operation: in-flight instruction discarded; rf_we drops immediately; no partial writeback.
- Legal opcodes: 0000 add, 0001 sub, 0100 mul, 0101 div, 0111 move, 1000 swap, 1001 and, 1011 or. All others are illegal.
- alu_op is driven with the opcode value unchanged.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to READ. With valid low, stay in IDLE.
- READ (1 cycle): rf_raddr1=rs, rf_raddr2=rt. Capture rf_rdata1/2 into operand regs.
  - Illegal opcode: pulse illegal, go to IDLE.
  - div with rdata2==0: pulse div_zero, go to IDLE.
  - Otherwise go to EXEC.
- EXEC: alu_data1, alu_data2 and alu_op are registered and stable for the whole state.
  - Duration is 1 cycle, or MULDIV_CYCLES for mul/div; a down-counter is loaded on entry.
  - On the final EXEC cycle, capture alu_lower/alu_upper into result regs, then go to WB_LO.
- WB_LO (1 cycle): rf_we=1, rf_wdata=lower result.
  - rf_waddr=rd for all ops except swap; for swap, rf_waddr=rs.
  - Swap goes to WB_HI; all other ops go to IDLE.
- WB_HI (swap only, 1 cycle): rf_we=1, rf_waddr=rt, rf_wdata=upper result, then go to IDLE.
- Swap semantics: ALU Lower=Data2 (rt value) and Upper=Data1 (rs value), so rs and rt exchange contents. rd is ignored.
- Swap with rs==rt: two writes of the same value; the register is unchanged.
- Latency, accept at cycle T:
  - Single-cycle op: rf_we at T+3, instr_ready at T+4.
  - mul/div: rf_we at T+2+MULDIV_CYCLES.
  - Swap: one extra cycle.
- rf_we is low in every state except WB_LO and WB_HI. The alu_* outputs hold their last values outside EXEC.
- No width extension or saturation: results are DATA_W bits as returned by the ALU.
- Writeback completes before the next READ, so a read-after-write on a back-to-back instruction sees the new value.

Test Plan:
- Reset mid-EXEC of a mul, with r1=3, r2=5 -> rf_we never rises; all outputs 0; instr_ready=1 one cycle after rst release.
- add r3=r1+r2 with r1=10, r2=7 -> alu_op=0000, data1=10, data2=7; rf_we=1, waddr=3, wdata=17 at T+3; instr_ready high at T+4.
- mul r4=r1*r2 with r1=3, r2=5, MULDIV_CYCLES=4 -> alu_op=0100 stable for 4 EXEC cycles; rf_we at T+6 with wdata=15.
- swap rs=1, rt=2 with r1=0x00AA, r2=0x1FFFF -> WB_LO writes r1=0x1FFFF, WB_HI writes r2=0x00AA on consecutive cycles.
- opcode 0011, then div r5=r1/r0 with r0=0 -> illegal pulses at T+1, div_zero pulses at its READ; no rf_we for either instruction.
- Back-to-back add r1=r1+r2 (r1=1, r2=1) twice with instr_valid held high -> writes 2, then 3; second accepted only when instr_ready returns.
